uart_tx_arbiter: RTL and testbench

- Shares one uart_tx instance between N_REQ byte-stream requesters, one packet at a time, with round-robin fairness.
- Sits between the requesters (telemetry, command echo, debug) and the uart_tx valid/ready handshake.
- The grant is packet-atomic: once a requester wins, only its bytes reach the UART until its last byte is accepted or a gap timeout fires.

---
 rtl/uart_tx_arbiter.sv | 133 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx between N_REQ byte-stream requesters.
// Grants are packet-atomic and round-robin. A granted requester that stays idle
// for MAX_GAP cycles mid-packet loses its grant, and abort pulses for one cycle.
// Optional: define UART_ARB_HDR_EN to send a header byte (8'hA0 | grant_id)
// before each packet.
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int MAX_GAP = 1000,
  localparam int GW     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [GW-1:0]      grant_id,
  output logic               busy,
  output logic               abort
);

  localparam int          CW = $clog2(MAX_GAP + 1);
  localparam int unsigned NR = N_REQ;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
`ifdef UART_ARB_HDR_EN
  localparam logic [1:0] HDR    = 2'd2;
`endif

  logic [1:0]    state;
  logic [GW-1:0] rr_ptr;
  logic [CW-1:0] gap_cnt;
  logic          found;
  logic [GW-1:0] pick;
  logic          sel_valid;
  logic          sel_last;
  logic [7:0]    sel_data;

  // Round-robin search starting one past the last winner, wrapping around
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned i = 1; i <= NR; i++) begin
      idx = (32'(rr_ptr) + i) % NR;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end
  end

  // Granted requester's signals
  always_comb begin
    sel_valid = req_valid[grant_id];
    sel_last  = req_last[grant_id];
    sel_data  = req_data[32'(grant_id)*8 +: 8];
  end

  // Combinational pass-through to uart_tx, steered by state and grant
  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = '0;
    req_ready = '0;
    case (state)
      STREAM: begin
        tx_valid            = sel_valid;
        tx_data             = sel_data;
        req_ready[grant_id] = tx_ready;
      end
`ifdef UART_ARB_HDR_EN
      HDR: begin
        tx_valid = 1'b1;
        tx_data  = 8'hA0 | 8'(grant_id);
      end
`endif
      default: ;
    endcase
    busy = (state != IDLE);
  end

  // FSM, grant registers, gap counter and abort pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      rr_ptr   <= GW'(N_REQ - 1);
      grant_id <= '0;
      gap_cnt  <= '0;
      abort    <= 1'b0;
    end else begin
      abort <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            grant_id <= pick;
            rr_ptr   <= pick;
            gap_cnt  <= '0;
`ifdef UART_ARB_HDR_EN
            state    <= HDR;
`else
            state    <= STREAM;
`endif
          end
        end
`ifdef UART_ARB_HDR_EN
        HDR: begin
          if (tx_ready) state <= STREAM;
        end
`endif
        STREAM: begin
          // A valid byte always clears the counter, so a beat on the expiry cycle wins
          if (sel_valid) begin
            gap_cnt <= '0;
            if (tx_ready && sel_last) state <= IDLE;
          end else if (gap_cnt == CW'(MAX_GAP - 1)) begin
            state   <= IDLE;
            abort   <= 1'b1;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter (N_REQ=4, MAX_GAP=8).
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] req_data;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [1:0]  grant_id;
  logic        busy;
  logic        abort;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(.N_REQ(4), .MAX_GAP(8)) dut (
    .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid),
    .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .grant_id(grant_id),
    .busy(busy), .abort(abort)
  );

  always #5 clk = ~clk;

  task automatic do_reset;
    rst = 1'b0; req_valid = '0; req_last = '0; req_data = '0; tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0; req_valid = '1; req_last = '1; req_data = '0; tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant got %0d want 0", grant_id); end
    checks++; if (abort !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL reset_abort_data got %b/%h want 0/00", abort, tx_data); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (grant_id !== 2'd0 || busy !== 1'b1) begin errors++; $display("FAIL reset_first_grant got %0d busy %b want 0 busy 1", grant_id, busy); end
    // Reset mid-packet drops the grant
    rst = 1'b0; req_valid = '0; req_last = '0; tx_ready = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin errors++; $display("FAIL reset_midpkt got busy %b tx_valid %b want 0 0", busy, tx_valid); end
    rst = 1'b1;
  endtask

  task automatic test_single;
    logic [7:0] exp_b [3];
    int k, cyc;
    logic xfer, bad_ready;
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
    k = 0; cyc = 0; bad_ready = 1'b0;
    req_valid = 4'b0100;
    while (k < 3 && cyc < 200) begin
      tx_ready = (cyc % 10 == 9);
      req_data[23:16] = exp_b[k];
      req_last = (k == 2) ? 4'b0100 : 4'b0000;
      @(negedge clk);
      if (req_ready !== (tx_ready ? 4'b0100 : 4'b0000)) bad_ready = 1'b1;
      xfer = tx_valid && tx_ready;
      if (xfer) begin
        checks++;
        if (tx_data !== exp_b[k]) begin errors++; $display("FAIL single_byte%0d got %h want %h", k, tx_data, exp_b[k]); end
      end
      @(posedge clk); #1;
      if (xfer) k++;
      cyc++;
    end
    tx_ready = 1'b0; req_valid = '0; req_last = '0;
    checks++; if (k != 3) begin errors++; $display("FAIL single_count got %0d want 3", k); end
    checks++; if (bad_ready) begin errors++; $display("FAIL single_ready got mismatch want req_ready[2]==tx_ready"); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin errors++; $display("FAIL single_idle got busy %b tx_valid %b want 0 0", busy, tx_valid); end
  endtask

  task automatic test_fair;
    int b [4];
    int n, cyc, exp_req;
    logic [7:0] exp_data;
    logic [3:0] rdy;
    do_reset;
    for (int i = 0; i < 4; i++) b[i] = 0;
    n = 0; cyc = 0;
    tx_ready = 1'b1; req_valid = 4'hF;
    while (n < 12 && cyc < 100) begin
      for (int i = 0; i < 4; i++) begin
        req_data[8*i +: 8] = 8'(i*16 + b[i]);
        req_last[i] = (b[i] == 1);
      end
      @(negedge clk);
      rdy = req_ready;
      if (tx_valid && tx_ready) begin
        exp_req  = (n / 2) % 4;
        exp_data = 8'(exp_req*16 + n % 2);
        checks++;
        if (grant_id !== 2'(exp_req) || tx_data !== exp_data) begin
          errors++; $display("FAIL fair_beat%0d got g%0d %h want g%0d %h", n, grant_id, tx_data, exp_req, exp_data);
        end
        n++;
      end
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) if (rdy[i]) b[i] = 1 - b[i];
      cyc++;
    end
    checks++; if (n != 12) begin errors++; $display("FAIL fair_count got %0d want 12", n); end
    req_valid = '0; req_last = '0; tx_ready = 1'b0;
  endtask

  task automatic test_gap;
    logic [8:0] ab;
    do_reset;
    tx_ready = 1'b1; req_valid = 4'b1010; req_last = 4'b1000;
    req_data[15:8] = 8'h77; req_data[31:24] = 8'h99;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (grant_id !== 2'd1 || tx_valid !== 1'b1 || tx_data !== 8'h77) begin
      errors++; $display("FAIL gap_grant1 got g%0d v%b %h want g1 v1 77", grant_id, tx_valid, tx_data); end
    @(posedge clk); #1;
    req_valid = 4'b1000;
    ab = '0;
    for (int n = 0; n < 9; n++) begin
      @(negedge clk);
      ab[n] = abort;
      if (n == 0) begin
        checks++; if (tx_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL gap_stall got v%b busy %b want v0 busy 1", tx_valid, busy); end
      end
      if (n == 8) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gap_idle got busy %b want 0", busy); end
      end
      @(posedge clk); #1;
    end
    checks++; if (ab !== 9'h100) begin errors++; $display("FAIL gap_abort_timing got %b want 100000000", ab); end
    @(negedge clk);
    checks++; if (grant_id !== 2'd3 || tx_data !== 8'h99 || abort !== 1'b0) begin
      errors++; $display("FAIL gap_next_grant got g%0d %h abort %b want g3 99 abort 0", grant_id, tx_data, abort); end
    @(posedge clk); #1;
    req_valid = '0; req_last = '0; tx_ready = 1'b0;
  endtask

  task automatic test_race;
    logic seen_abort;
    do_reset;
    tx_ready = 1'b1; req_valid = 4'b0010; req_last = '0; req_data[15:8] = 8'h44;
    @(posedge clk); #1;
    @(posedge clk); #1;
    req_valid = '0;
    seen_abort = 1'b0;
    for (int n = 0; n < 7; n++) begin
      @(negedge clk);
      seen_abort |= abort;
      @(posedge clk); #1;
    end
    req_valid = 4'b0010; req_data[15:8] = 8'h55;
    @(negedge clk);
    seen_abort |= abort;
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h55 || req_ready !== 4'b0010) begin
      errors++; $display("FAIL race_beat got v%b %h rdy %b want v1 55 rdy 0010", tx_valid, tx_data, req_ready); end
    @(posedge clk); #1;
    req_data[15:8] = 8'h66; req_last = 4'b0010;
    @(negedge clk);
    checks++; if (abort !== 1'b0 || busy !== 1'b1 || tx_data !== 8'h66) begin
      errors++; $display("FAIL race_continue got abort %b busy %b %h want 0 1 66", abort, busy, tx_data); end
    checks++; if (seen_abort !== 1'b0) begin errors++; $display("FAIL race_no_abort got early abort want none"); end
    @(posedge clk); #1;
    req_valid = '0; req_last = '0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL race_end got busy %b want 0", busy); end
    tx_ready = 1'b0;
  endtask

`ifdef UART_ARB_HDR_EN
  task automatic test_hdr;
    do_reset;
    tx_ready = 1'b1; req_valid = 4'b1000; req_last = 4'b1000; req_data[31:24] = 8'h5A;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'hA3 || req_ready !== 4'b0) begin
      errors++; $display("FAIL hdr_header got v%b %h rdy %b want v1 a3 rdy 0000", tx_valid, tx_data, req_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (tx_data !== 8'h5A || req_ready !== 4'b1000) begin
      errors++; $display("FAIL hdr_payload got %h rdy %b want 5a rdy 1000", tx_data, req_ready); end
    @(posedge clk); #1;
    req_valid = '0; req_last = '0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hdr_end got busy %b want 0", busy); end
  endtask
`endif

  initial begin
    rst = 1'b0; req_valid = '0; req_last = '0; req_data = '0; tx_ready = 1'b0;
    test_reset;
`ifdef UART_ARB_HDR_EN
    test_hdr;
`else
    test_single;
    test_fair;
    test_gap;
    test_race;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
